sram_sp_arbiter: RTL and testbench

- Controller for one single-port 128x32 SRAM macro.
- Macro pins: CEB and WEB are active-low. Q is registered and is only meaningful the cycle after a read; it carries random data at all other times.
- After reset the block zero-fills the array, then shares the single port between one read requester and one write requester using round-robin arbitration.
- It sits between cache/metadata logic and the macro instance; only this block drives the macro pins.

---
 rtl/sram_sp_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_sp_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_arbiter.sv
// Single-port SRAM controller: zero-fills the macro after reset, then shares
// the port between one read and one write requester with round-robin priority.
//
// state | meaning
// INIT  | writing zeros to every address, requesters held off
// RUN   | port open, read/write arbitration active
module sram_sp_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 7,
    parameter int DEPTH     = 128,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              init_done,
    output logic              sram_CEB,
    output logic              sram_WEB,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_D,
    input  logic [DATA_W-1:0] sram_Q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              rr_ptr;
    logic              resp_v_q;
    logic [DATA_W-1:0] hold_q;
    logic              grant_r;
    logic              grant_w;

    assign init_done = (state == ST_RUN);

    // rr_ptr = 0 favours the read side on a tie, 1 favours the write side.
    always_comb begin
        grant_r = 1'b0;
        grant_w = 1'b0;
        if (!reset && state == ST_RUN) begin
            if (r_req_valid && (!w_req_valid || !rr_ptr)) begin
                grant_r = 1'b1;
            end else if (w_req_valid) begin
                grant_w = 1'b1;
            end
        end
    end

    assign r_req_ready = grant_r;
    assign w_req_ready = grant_w;

    // The fill is suppressed while reset is held so the macro sees no stray writes.
    always_comb begin
        sram_CEB = 1'b1;
        sram_WEB = 1'b1;
        sram_A   = '0;
        sram_D   = '0;
        if (!reset && state == ST_INIT) begin
            sram_CEB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = init_cnt;
        end else if (grant_r) begin
            sram_CEB = 1'b0;
            sram_A   = r_req_addr;
        end else if (grant_w) begin
            sram_CEB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = w_req_addr;
            sram_D   = w_req_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RESET_STATE;
            init_cnt <= '0;
            rr_ptr   <= 1'b0;
            resp_v_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (grant_r) begin
                        rr_ptr <= 1'b1;
                    end else if (grant_w) begin
                        rr_ptr <= 1'b0;
                    end
                end
                default: state <= RESET_STATE;
            endcase
            resp_v_q <= grant_r;
            if (resp_v_q) begin
                hold_q <= sram_Q;
            end
        end
    end

    // Q is only trustworthy the cycle after a read; otherwise replay the last value.
    assign r_resp_valid = resp_v_q;
    assign r_resp_data  = resp_v_q ? sram_Q : hold_q;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Bench for sram_sp_arbiter: behavioural macro models, reference-memory
// scoreboard for read data, directed fill/arbitration/reset sequences.
module tb_sram_sp_arbiter;

    localparam int DW = 32;
    localparam int AW = 7;

    logic          clock = 1'b0;
    logic          reset;
    logic          r_req_valid, r_req_ready, r_resp_valid;
    logic [AW-1:0] r_req_addr;
    logic [DW-1:0] r_resp_data;
    logic          w_req_valid, w_req_ready;
    logic [AW-1:0] w_req_addr;
    logic [DW-1:0] w_req_data;
    logic          init_done, sram_CEB, sram_WEB;
    logic [AW-1:0] sram_A;
    logic [DW-1:0] sram_D, sram_Q;

    logic          z_reset;
    logic          z_r_req_valid, z_r_req_ready, z_r_resp_valid;
    logic [AW-1:0] z_r_req_addr;
    logic [DW-1:0] z_r_resp_data;
    logic          z_w_req_valid, z_w_req_ready;
    logic [AW-1:0] z_w_req_addr;
    logic [DW-1:0] z_w_req_data;
    logic          z_init_done, z_sram_CEB, z_sram_WEB;
    logic [AW-1:0] z_sram_A;
    logic [DW-1:0] z_sram_D, z_sram_Q;

    always #5 clock = ~clock;

    sram_sp_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(128), .INIT_ZERO(1'b1)) dut (
        .clock(clock), .reset(reset),
        .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
        .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
        .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
        .w_req_data(w_req_data), .init_done(init_done),
        .sram_CEB(sram_CEB), .sram_WEB(sram_WEB), .sram_A(sram_A), .sram_D(sram_D),
        .sram_Q(sram_Q)
    );

    sram_sp_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(128), .INIT_ZERO(1'b0)) dut_nofill (
        .clock(clock), .reset(z_reset),
        .r_req_valid(z_r_req_valid), .r_req_ready(z_r_req_ready), .r_req_addr(z_r_req_addr),
        .r_resp_valid(z_r_resp_valid), .r_resp_data(z_r_resp_data),
        .w_req_valid(z_w_req_valid), .w_req_ready(z_w_req_ready), .w_req_addr(z_w_req_addr),
        .w_req_data(z_w_req_data), .init_done(z_init_done),
        .sram_CEB(z_sram_CEB), .sram_WEB(z_sram_WEB), .sram_A(z_sram_A), .sram_D(z_sram_D),
        .sram_Q(z_sram_Q)
    );

    // Macro models: registered Q, random whenever the cycle was not a read.
    logic [DW-1:0] mem   [128];
    logic [DW-1:0] z_mem [128];

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]   <= $urandom;
            z_mem[i] <= $urandom;
        end
    end

    always @(posedge clock) begin
        if (!sram_CEB && !sram_WEB) mem[sram_A] <= sram_D;
        if (!sram_CEB && sram_WEB) sram_Q <= mem[sram_A];
        else sram_Q <= $urandom;
        if (!z_sram_CEB && !z_sram_WEB) z_mem[z_sram_A] <= z_sram_D;
        if (!z_sram_CEB && z_sram_WEB) z_sram_Q <= z_mem[z_sram_A];
        else z_sram_Q <= $urandom;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: reference contents track intended writes; reads push expected data.
    logic [DW-1:0] ref_mem [128];
    logic [DW-1:0] exp_q [$];

    always @(negedge clock) begin
        if (!reset) begin
            if (r_resp_valid) begin
                if (exp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                else chk("resp_data", r_resp_data, exp_q.pop_front());
            end
            if (r_req_ready || w_req_ready) chk("onehot", {31'd0, r_req_ready & w_req_ready}, 32'd0);
            if (r_req_ready) exp_q.push_back(ref_mem[r_req_addr]);
            if (w_req_ready) ref_mem[w_req_addr] = w_req_data;
        end
    end

    int cnt;
    logic [DW-1:0] wd;

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        reset = 1'b1; r_req_valid = 1'b1; w_req_valid = 1'b1;
        r_req_addr = '0; w_req_addr = '0; w_req_data = '0;
        z_reset = 1'b1; z_r_req_valid = 1'b1; z_r_req_addr = 7'd5;
        z_w_req_valid = 1'b0; z_w_req_addr = '0; z_w_req_data = '0;

        tick();
        @(negedge clock);
        chk("rst_r_ready", {31'd0, r_req_ready}, 32'd0);
        chk("rst_w_ready", {31'd0, w_req_ready}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_resp_valid", {31'd0, r_resp_valid}, 32'd0);
        chk("rst_z_r_ready", {31'd0, z_r_req_ready}, 32'd0);
        tick();

        // Fill: requests held off, read of 0x7F waits for the port.
        reset = 1'b0; w_req_valid = 1'b0; r_req_addr = 7'h7F;
        for (int c = 0; c < 128; c++) begin
            @(negedge clock);
            chk("fill_ceb", {31'd0, sram_CEB}, 32'd0);
            chk("fill_web", {31'd0, sram_WEB}, 32'd0);
            chk("fill_a", {25'd0, sram_A}, 32'(c));
            chk("fill_d", sram_D, 32'd0);
            chk("fill_done_low", {31'd0, init_done}, 32'd0);
            chk("fill_ready", {30'd0, r_req_ready, w_req_ready}, 32'd0);
            tick();
        end
        @(negedge clock);
        chk("fill_done_high", {31'd0, init_done}, 32'd1);
        chk("post_fill_r_ready", {31'd0, r_req_ready}, 32'd1);
        chk("post_fill_a", {25'd0, sram_A}, 32'h7F);
        tick();
        r_req_valid = 1'b0;
        @(negedge clock);
        chk("post_fill_resp_v", {31'd0, r_resp_valid}, 32'd1);
        chk("post_fill_resp_d", r_resp_data, 32'd0);
        tick();

        // Write then read of the same address on the next cycle.
        w_req_valid = 1'b1; w_req_addr = 7'h15; w_req_data = 32'hDEADBEEF;
        @(negedge clock);
        chk("wr_ready", {31'd0, w_req_ready}, 32'd1);
        chk("wr_d", sram_D, 32'hDEADBEEF);
        chk("wr_web", {31'd0, sram_WEB}, 32'd0);
        tick();
        w_req_valid = 1'b0; r_req_valid = 1'b1; r_req_addr = 7'h15;
        @(negedge clock);
        chk("rd_ready", {31'd0, r_req_ready}, 32'd1);
        tick();
        r_req_valid = 1'b0;
        @(negedge clock);
        chk("raw_resp_v", {31'd0, r_resp_valid}, 32'd1);
        chk("raw_resp_d", r_resp_data, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clock);
            chk("hold_v", {31'd0, r_resp_valid}, 32'd0);
            chk("hold_d", r_resp_data, 32'hDEADBEEF);
            chk("idle_ceb", {31'd0, sram_CEB}, 32'd1);
        end

        // Reset mid-fill at address 60; the array is refilled from 0.
        tick();
        reset = 1'b1;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        tick();
        reset = 1'b0;
        repeat (60) tick();
        @(negedge clock);
        chk("mid_fill_a60", {25'd0, sram_A}, 32'd60);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("refill_a0", {25'd0, sram_A}, 32'd0);
        cnt = 0;
        while (!init_done && cnt < 300) begin
            cnt++;
            tick();
            @(negedge clock);
        end
        chk("refill_len", 32'(cnt), 32'd128);

        // Contention from reset priority: R W R W R W.
        for (int i = 0; i < 6; i++) begin
            tick();
            wd = $urandom;
            r_req_valid = 1'b1; r_req_addr = 7'(8'h1F + i);
            w_req_valid = 1'b1; w_req_addr = 7'(8'h20 + i); w_req_data = wd;
            @(negedge clock);
            chk("tie_r", {31'd0, r_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie_w", {31'd0, w_req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        tick();
        w_req_valid = 1'b0; r_req_addr = 7'h25;
        @(negedge clock);
        chk("lone_r", {31'd0, r_req_ready}, 32'd1);
        tick();
        r_req_valid = 1'b0; w_req_valid = 1'b1; w_req_addr = 7'h30; w_req_data = 32'h12345678;
        @(negedge clock);
        chk("lone_w", {31'd0, w_req_ready}, 32'd1);
        tick();
        r_req_valid = 1'b1; r_req_addr = 7'h30; w_req_addr = 7'h31; w_req_data = 32'hA5A5A5A5;
        @(negedge clock);
        chk("after_w_tie_r", {31'd0, r_req_ready}, 32'd1);
        chk("after_w_tie_w", {31'd0, w_req_ready}, 32'd0);
        tick();
        r_req_valid = 1'b0; w_req_valid = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        // No-fill variant: port open straight out of reset.
        chk("nofill_rst_ready", {31'd0, z_r_req_ready}, 32'd0);
        tick();
        z_reset = 1'b0;
        @(negedge clock);
        chk("nofill_done", {31'd0, z_init_done}, 32'd1);
        chk("nofill_r_ready", {31'd0, z_r_req_ready}, 32'd1);
        chk("nofill_ceb", {31'd0, z_sram_CEB}, 32'd0);
        chk("nofill_web", {31'd0, z_sram_WEB}, 32'd1);
        chk("nofill_a", {25'd0, z_sram_A}, 32'd5);
        tick();
        z_r_req_valid = 1'b0;
        @(negedge clock);
        chk("nofill_resp_v", {31'd0, z_r_resp_valid}, 32'd1);
        tick();
        @(negedge clock);
        chk("nofill_resp_v_low", {31'd0, z_r_resp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
